// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a writing stage targets the given source register (x0 never matches).
  function automatic logic rd_hits(input logic wr, input logic [4:0] rd, input logic [4:0] src);
    return wr && (rd != REG_X0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source operand; MEM result beats WB result.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_rd_wr,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_rd_wr,
  output logic [1:0] fwd_sel
);

  // Priority select: youngest producer (MEM) first, then WB, else register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (rd_hits(mem_rd_wr, mem_rd_addr, src_addr)) begin
      fwd_sel = FWD_MEM;
    end else if (rd_hits(wb_rd_wr, wb_rd_addr, src_addr)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing: stage enables/flushes, load-use and branch
// handling, data-memory wait FSM with timeout, forwarding selects, stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_wr,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_rd_wr,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_wr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic [7:0]       wait_cnt_nxt_s;
  logic             mem_err_r;
  logic             set_err_s;
  logic [CNT_W-1:0] stall_cycles_r;
  logic             freeze_s;
  logic             load_use_s;

  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_cycles_r;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_is_load && ex_rd_wr && (ex_rd_addr != REG_X0)) begin
      load_use_s = (id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                   (id_rs2_used && (id_rs2_addr == ex_rd_addr));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Pipeline freezes whenever an outstanding data access has not completed;
  // once waiting, only dmem_ready releases it.
  always_comb begin
    freeze_s = 1'b0;
    case (state_r)
      S_RUN:      freeze_s = mem_req && !dmem_ready;
      S_MEM_WAIT: freeze_s = !dmem_ready;
      default:    freeze_s = !dmem_ready;
    endcase
  end

  // Next-state, wait counter and stage control. On release the held EX
  // instruction is re-evaluated, so normal hazard handling applies then.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    set_err_s      = 1'b0;
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;

    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (freeze_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      if (state_r == S_RUN) begin
        state_nxt_s    = S_MEM_WAIT;
        wait_cnt_nxt_s = 8'd0;
      end else if (wait_cnt_r >= WAIT_LAST) begin
        set_err_s = 1'b1;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
      end
    end else begin
      state_nxt_s    = S_RUN;
      wait_cnt_nxt_s = 8'd0;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_s) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  // State, wait counter, sticky timeout flag and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_RUN;
      wait_cnt_r     <= 8'd0;
      mem_err_r      <= 1'b0;
      stall_cycles_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_r | set_err_s;
      if (!pc_en) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  fwd_unit u_fwd_a (
    .src_addr    (id_rs1_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_wr   (mem_rd_wr),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_wr    (wb_rd_wr),
    .fwd_sel     (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .src_addr    (id_rs2_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_wr   (mem_rd_wr),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_wr    (wb_rd_wr),
    .fwd_sel     (fwd_b_sel)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver pushes hand-computed
// expectations into a scoreboard queue, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_rd_wr, ex_is_load, ex_branch_taken;
  logic        mem_rd_wr, mem_req, dmem_ready, wb_rd_wr;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_flush, mem_err;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cycles;

  typedef struct {
    string       name;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, mem_wb}
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_FRZ  = 5'b00001;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_FRZ  = 3'b001;
  localparam logic [2:0] FL_LU   = 3'b010;
  localparam logic [2:0] FL_BR   = 3'b110;
  localparam logic [1:0] RF = 2'd0, MEMF = 2'd1, WBF = 2'd2;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wr(ex_rd_wr), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wr(mem_rd_wr), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .wb_rd_addr(wb_rd_addr), .wb_rd_wr(wb_rd_wr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd_addr = 5'd0; ex_rd_wr = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_rd_addr = 5'd0; mem_rd_wr = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    wb_rd_addr = 5'd0; wb_rd_wr = 1'b0;
  endtask

  // Inputs for this cycle are already applied; record the expectation and
  // advance to just after the next rising edge.
  task automatic step(input string name, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic err, input logic [31:0] stall);
    exp_t e;
    e.name = name; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err; e.stall = stall;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [4:0] en_a;
      logic [2:0] fl_a;
      e    = sb.pop_front();
      en_a = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
      fl_a = {if_id_flush, id_ex_flush, mem_wb_flush};
      total++;
      if (en_a !== e.en || fl_a !== e.fl || fwd_a_sel !== e.fa || fwd_b_sel !== e.fb ||
          mem_err !== e.err || stall_cycles !== e.stall) begin
        bad++;
        $display("FAIL %s: got en=%b fl=%b fa=%0d fb=%0d err=%b stall=%0d, want en=%b fl=%b fa=%0d fb=%0d err=%b stall=%0d",
                 e.name, en_a, fl_a, fwd_a_sel, fwd_b_sel, mem_err, stall_cycles,
                 e.en, e.fl, e.fa, e.fb, e.err, e.stall);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", EN_NONE, FL_NONE, RF, RF, 1'b0, 32'd0);
    rst = 1'b0;
    step("idle", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd0);

    // Load-use on rs1, then on rs2
    ex_is_load = 1'b1; ex_rd_wr = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    step("lu_rs1", EN_LU, FL_LU, RF, RF, 1'b0, 32'd0);
    idle();
    step("after_lu", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd1);
    ex_is_load = 1'b1; ex_rd_wr = 1'b1; ex_rd_addr = 5'd9; id_rs2_addr = 5'd9; id_rs2_used = 1'b1;
    step("lu_rs2", EN_LU, FL_LU, RF, RF, 1'b0, 32'd1);
    // No hazard: destination x0, or source not used
    ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
    step("lu_x0", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd2);
    ex_rd_addr = 5'd9; id_rs2_addr = 5'd9; id_rs2_used = 1'b0;
    step("lu_unused", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd2);

    // Branch colliding with load-use: branch wins, no stall
    id_rs2_used = 1'b1; ex_branch_taken = 1'b1;
    step("br_vs_lu", EN_ALL, FL_BR, RF, RF, 1'b0, 32'd2);
    idle();
    ex_branch_taken = 1'b1;
    step("branch", EN_ALL, FL_BR, RF, RF, 1'b0, 32'd2);

    // Forwarding
    idle();
    mem_rd_addr = 5'd7; mem_rd_wr = 1'b1; wb_rd_addr = 5'd7; wb_rd_wr = 1'b1;
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd3;
    step("fwd_mem_prio", EN_ALL, FL_NONE, MEMF, RF, 1'b0, 32'd2);
    mem_rd_wr = 1'b0;
    step("fwd_wb", EN_ALL, FL_NONE, WBF, RF, 1'b0, 32'd2);
    mem_rd_addr = 5'd0; mem_rd_wr = 1'b1; wb_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    step("fwd_x0", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd2);
    mem_rd_addr = 5'd12; mem_rd_wr = 1'b0; wb_rd_addr = 5'd12; id_rs1_addr = 5'd1; id_rs2_addr = 5'd12;
    step("fwd_b_wb", EN_ALL, FL_NONE, RF, WBF, 1'b0, 32'd2);

    // Access completing immediately: no freeze
    idle();
    mem_req = 1'b1; dmem_ready = 1'b1;
    step("mem_fast", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd2);

    // Memory wait: three frozen cycles, branch ignored while frozen, release
    dmem_ready = 1'b0;
    step("mw_run_frz", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd2);
    ex_branch_taken = 1'b1;
    step("mw_wait1", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd3);
    ex_branch_taken = 1'b0;
    step("mw_wait2", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd4);
    dmem_ready = 1'b1;
    step("mw_release", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd5);
    idle();
    step("mw_back_run", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd5);

    // Timeout with MEM_TIMEOUT=4: flag rises after four wait cycles and sticks
    mem_req = 1'b1;
    step("to_run_frz", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd5);
    step("to_wait0", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd6);
    step("to_wait1", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd7);
    step("to_wait2", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd8);
    step("to_wait3", EN_FRZ, FL_FRZ, RF, RF, 1'b0, 32'd9);
    step("to_err", EN_FRZ, FL_FRZ, RF, RF, 1'b1, 32'd10);
    dmem_ready = 1'b1;
    step("to_release", EN_ALL, FL_NONE, RF, RF, 1'b1, 32'd11);
    idle();
    step("to_sticky", EN_ALL, FL_NONE, RF, RF, 1'b1, 32'd11);

    // Reset in the middle of a wait
    mem_req = 1'b1;
    step("rw_run_frz", EN_FRZ, FL_FRZ, RF, RF, 1'b1, 32'd11);
    step("rw_wait", EN_FRZ, FL_FRZ, RF, RF, 1'b1, 32'd12);
    rst = 1'b1;
    step("rw_reset", EN_NONE, FL_NONE, RF, RF, 1'b0, 32'd0);
    rst = 1'b0;
    idle();
    step("rw_resume", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd0);
    ex_is_load = 1'b1; ex_rd_wr = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    step("rw_lu", EN_LU, FL_LU, RF, RF, 1'b0, 32'd0);
    idle();
    step("rw_after_lu", EN_ALL, FL_NONE, RF, RF, 1'b0, 32'd1);

    for (int i = 0; i < 4; i++) begin
      if (sb.size() > 0) begin
        @(negedge clk);
        #1;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the five-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Drives enable and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates operand forwarding selects.
- Owns the data-memory wait state machine.
- Keeps a stall-cycle counter for performance monitoring.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for dmem_ready before flagging mem_err (range 2..255)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
id_rs1_addr  in  5  rs1 of instruction in ID
id_rs2_addr  in  5  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd_addr  in  5  rd in EX
ex_rd_wr  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump (redirect)
mem_rd_addr  in  5  rd in MEM (EX/MEM register output)
mem_rd_wr  in  1  MEM instruction writes rd
mem_req  in  1  MEM instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
wb_rd_addr  in  5  rd in WB (MEM/WB register output)
wb_rd_wr  in  1  WB instruction writes rd
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads bubble
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
mem_wb_flush  out  1  MEM/WB loads bubble
fwd_a_sel  out  2  EX operand A source
fwd_b_sel  out  2  EX operand B source
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- FSM states: S_RUN and S_MEM_WAIT.
- Registered elements: the FSM state, an 8-bit wait counter, mem_err and stall_cycles. All other outputs are combinational from state and inputs.
- Reset (async) values: state=S_RUN, wait counter=0, mem_err=0, stall_cycles=0.
- While rst is high, all *_en=0 and all *_flush=0.

S_RUN:
- If mem_req=1 and dmem_ready=0, go to S_MEM_WAIT next cycle. In this same cycle apply the freeze rule below.

Freeze rule (mem_req=1 and dmem_ready=0, in either state):
- pc_en = if_id_en = id_ex_en = ex_mem_en = 0.
- mem_wb_en=1 with mem_wb_flush=1, so WB sees a bubble and no duplicate write occurs.
- ex_branch_taken and load-use are ignored. The frozen EX instruction re-resolves after release.

S_MEM_WAIT:
- Apply the freeze rule while dmem_ready=0. The wait counter increments each cycle.
- dmem_ready=1: all enables=1, counter clears, return to S_RUN. The access retires on this cycle.
- Counter reaches MEM_TIMEOUT-1 with no ready: set mem_err=1 (sticky until reset) and remain in S_MEM_WAIT.

Load-use (S_RUN, no freeze):
- Condition: ex_is_load=1, ex_rd_wr=1, ex_rd_addr≠0, and an ID source matches it (id_rsN_used=1 and id_rsN_addr==ex_rd_addr).
- Response: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble per occurrence.

Branch (S_RUN, no freeze):
- ex_branch_taken=1 gives if_id_flush=1 and id_ex_flush=1, with pc_en=1 so the redirect is taken.
- When branch and load-use occur together, branch wins. No stall is applied because the younger instruction is squashed.

Default: all enables=1, all flushes=0.

Forwarding (independent of FSM, per operand):
- fwd_*_sel=FWD_MEM (1) if mem_rd_wr=1, mem_rd_addr≠0 and mem_rd_addr==src.
- Else FWD_WB (2) under the same test on wb_*.
- Else FWD_RF (0). MEM has priority over WB. Register x0 is never forwarded.

stall_cycles:
- +1 every non-reset cycle with pc_en=0. Wraps modulo 2^CNT_W.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum: S_RUN, S_MEM_WAIT
  - fwd_sel_e: FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2
  - REG_X0=5'd0
- Sub-module fwd_unit: purely combinational forwarding for one operand, instantiated twice (A and B).
- Hazard logic, FSM and counters stay in the top level.

Test Plan:
- Load-use: ex_is_load=1, ex_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. stall_cycles goes 0->1.
- Branch collides with load-use: load-use condition true and ex_branch_taken=1 in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cycles unchanged.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles (mem_wb_flush=1), release on the 4th cycle, stall_cycles=3, state back to S_RUN.
- Forwarding:
  - mem_rd_addr=wb_rd_addr=7, both writing, id source 7 -> FWD_MEM.
  - mem_rd_wr=0 -> FWD_WB.
  - Source x0 with matching rd=0 -> FWD_RF.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err rises after 4 wait cycles and stays high after a later dmem_ready.
- Reset mid-wait: assert rst while in S_MEM_WAIT -> immediately state=S_RUN, mem_err=0, stall_cycles=0, all enables 0. Normal flow resumes after rst is released.
